// File: rtl/ray_march_stepper.sv
// Sphere-tracing ray stepper: presents sample points to a fixed-latency SDF
// pipeline and advances each ray by the returned distance until hit, escape or budget.
module ray_march_stepper #(
  parameter int unsigned FP_W        = 32,
  parameter int unsigned FP_FRAC     = 16,
  parameter int unsigned SDF_LATENCY = 4,
  parameter int unsigned MAX_STEPS   = 64,
  parameter logic signed [FP_W-1:0] HIT_EPS  = 32'sh0000_0100,
  parameter logic signed [FP_W-1:0] MAX_DIST = 32'sh0010_0000,
  localparam int unsigned STEP_W = $clog2(MAX_STEPS + 1)
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                ray_valid_in,
  output logic                ray_ready_out,
  input  logic [3*FP_W-1:0]   ray_origin_in,
  input  logic [3*FP_W-1:0]   ray_dir_in,
  output logic                query_valid_out,
  output logic [3*FP_W-1:0]   query_point_out,
  input  logic [FP_W-1:0]     sdf_in,
  output logic                result_valid_out,
  input  logic                result_ready_in,
  output logic                hit_out,
  output logic                timeout_out,
  output logic [3*FP_W-1:0]   pos_out,
  output logic [FP_W-1:0]     t_out,
  output logic [STEP_W-1:0]   steps_out
);
  localparam int unsigned CNT_W = $clog2(SDF_LATENCY + 1);
  localparam int unsigned PW    = 2 * FP_W;

  typedef enum logic [1:0] {IDLE, MARCH, DONE} state_t;

  state_t                  state;
  logic [2:0][FP_W-1:0]    pos, dir, pos_new;
  logic signed [FP_W-1:0]  t, t_new, sdf_s;
  logic [STEP_W-1:0]       steps, steps_new;
  logic [CNT_W-1:0]        cnt;
  logic signed [PW-1:0]    prod;

  assign query_point_out = pos;
  assign pos_out         = pos;
  assign t_out           = t;
  assign steps_out       = steps;

  // Product kept at double width, then realigned to the fp binary point.
  always_comb begin
    sdf_s     = $signed(sdf_in);
    t_new     = t + sdf_s;
    steps_new = steps + 1'b1;
    prod      = '0;
    pos_new   = '0;
    for (int unsigned i = 0; i < 3; i++) begin
      prod       = PW'($signed(dir[i])) * PW'(sdf_s);
      pos_new[i] = pos[i] + FP_W'(prod >>> FP_FRAC);
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state            <= IDLE;
      ray_ready_out    <= 1'b1;
      query_valid_out  <= 1'b0;
      result_valid_out <= 1'b0;
      hit_out          <= 1'b0;
      timeout_out      <= 1'b0;
      pos              <= '0;
      dir              <= '0;
      t                <= '0;
      steps            <= '0;
      cnt              <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ray_valid_in) begin
            pos             <= ray_origin_in;
            dir             <= ray_dir_in;
            t               <= '0;
            steps           <= '0;
            cnt             <= '0;
            hit_out         <= 1'b0;
            timeout_out     <= 1'b0;
            ray_ready_out   <= 1'b0;
            query_valid_out <= 1'b1;
            state           <= MARCH;
          end
        end
        MARCH: begin
          if (cnt == CNT_W'(SDF_LATENCY)) begin
            steps <= steps_new;
            if (sdf_s < HIT_EPS) begin
              hit_out          <= 1'b1;
              query_valid_out  <= 1'b0;
              result_valid_out <= 1'b1;
              state            <= DONE;
            end else begin
              t   <= t_new;
              pos <= pos_new;
              cnt <= '0;
              if (t_new > MAX_DIST) begin
                query_valid_out  <= 1'b0;
                result_valid_out <= 1'b1;
                state            <= DONE;
              end else if (steps_new == STEP_W'(MAX_STEPS)) begin
                timeout_out      <= 1'b1;
                query_valid_out  <= 1'b0;
                result_valid_out <= 1'b1;
                state            <= DONE;
              end
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (result_ready_in) begin
            result_valid_out <= 1'b0;
            ray_ready_out    <= 1'b1;
            state            <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
